raymarch_pixel_sequencer: RTL and testbench

Drives the ray-marcher core's pixel request side and collects its shaded results. It raster-scans a WIDTH x HEIGHT frame and issues one Q11.21 screen coordinate pair per pixel with a single-cycle valid pulse. It then waits for the core's shade result and forwards that result as an AXI4-Stream video beat, with tuser marking start-of-frame and tlast marking end-of-line. Only one pixel is in flight at a time, so result ordering is trivially preserved.

---
 rtl/raymarch_pixel_sequencer_if.sv | 54 +++++
 rtl/raymarch_pixel_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_raymarch_pixel_sequencer.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/raymarch_pixel_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : raymarch_pixel_sequencer_if
//  Description : Bundles the two sides of the pixel sequencer. One side is the
//                coordinate request and shade result path to the ray-marcher
//                core. The other is the AXI4-Stream video output.
//  Revision    : 1.0  initial release
// ============================================================================
interface raymarch_pixel_sequencer_if #(
    parameter int CW = 32
);
    // Request and response path to the ray-marcher core
    logic [CW-1:0] screen_x;
    logic [CW-1:0] screen_y;
    logic          coord_valid;
    logic          shade_valid;
    logic [23:0]   shade_in;

    // AXI4-Stream video output
    logic [23:0]   m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tuser;
    logic          m_axis_tlast;

    // Sequencer side
    modport master (
        output screen_x,
        output screen_y,
        output coord_valid,
        input  shade_valid,
        input  shade_in,
        output m_axis_tdata,
        output m_axis_tvalid,
        input  m_axis_tready,
        output m_axis_tuser,
        output m_axis_tlast
    );

    // Core and video sink side
    modport slave (
        input  screen_x,
        input  screen_y,
        input  coord_valid,
        output shade_valid,
        output shade_in,
        input  m_axis_tdata,
        input  m_axis_tvalid,
        output m_axis_tready,
        input  m_axis_tuser,
        input  m_axis_tlast
    );
endinterface
`default_nettype wire

// File: rtl/raymarch_pixel_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : raymarch_pixel_sequencer
//  Description : Raster-scans a WIDTH x HEIGHT frame. For each pixel it issues
//                one fixed-point screen coordinate to the ray-marcher core,
//                waits for the shaded colour, and forwards it as an
//                AXI4-Stream video beat (tuser = start of frame,
//                tlast = end of line). Only one pixel is in flight at a time.
//  Revision    : 1.0  initial release
// ============================================================================
module raymarch_pixel_sequencer #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int FRAC   = 21,
    parameter int CW     = 32
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  start,
    input  wire logic                  continuous,
    raymarch_pixel_sequencer_if.master bus,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       spurious_err
);

    localparam int              c_xw     = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int              c_yw     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [c_xw-1:0] c_x_last = c_xw'(WIDTH - 1);
    localparam logic [c_yw-1:0] c_y_last = c_yw'(HEIGHT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    // Reset synchroniser state
    logic            r_rst_meta;
    logic            r_rst_sync;

    // Scan state
    state_t          r_state;
    state_t          w_state_next;
    logic [c_xw-1:0] r_x;
    logic [c_xw-1:0] w_x_next;
    logic [c_yw-1:0] r_y;
    logic [c_yw-1:0] w_y_next;

    // Output holding registers
    logic [CW-1:0]   r_screen_x;
    logic [CW-1:0]   r_screen_y;
    logic [23:0]     r_tdata;
    logic            r_tuser;
    logic            r_tlast;
    logic            r_frame_done;
    logic            r_spurious_err;

    // Decoded conditions
    logic            w_last_x;
    logic            w_last_y;
    logic            w_handshake;
    logic            w_frame_end;
    logic            w_capture;
    logic [CW-1:0]   w_coord_x;
    logic [CW-1:0]   w_coord_y;

    assign w_last_x    = (r_x == c_x_last);
    assign w_last_y    = (r_y == c_y_last);
    assign w_handshake = (r_state == S_OUT) && bus.m_axis_tready;
    assign w_frame_end = w_handshake && w_last_x && w_last_y;
    assign w_capture   = (r_state == S_WAIT) && bus.shade_valid;

    // Integer pixel position scaled to the core's fixed-point format
    assign w_coord_x   = CW'(r_x) << FRAC;
    assign w_coord_y   = CW'(r_y) << FRAC;

    // Reset asserts immediately but releases only on a clock edge, so every
    // downstream flop leaves reset in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rst_meta <= 1'b1;
            r_rst_sync <= 1'b1;
        end else begin
            r_rst_meta <= 1'b0;
            r_rst_sync <= r_rst_meta;
        end
    end

    // State and scan position registers
    always_ff @(posedge clk or posedge r_rst_sync) begin
        if (r_rst_sync) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
        end else begin
            r_state <= w_state_next;
            r_x     <= w_x_next;
            r_y     <= w_y_next;
        end
    end

    // Next-state and scan advance. In IDLE, start is held off during the
    // frame_done cycle because busy is still reported high in that cycle.
    always_comb begin
        w_state_next = r_state;
        w_x_next     = r_x;
        w_y_next     = r_y;
        case (r_state)
            S_IDLE: begin
                if (start && !r_frame_done) begin
                    w_state_next = S_ISSUE;
                    w_x_next     = '0;
                    w_y_next     = '0;
                end
            end
            S_ISSUE: begin
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (bus.shade_valid) begin
                    w_state_next = S_OUT;
                end
            end
            S_OUT: begin
                if (bus.m_axis_tready) begin
                    if (!w_last_x) begin
                        w_x_next     = r_x + c_xw'(1);
                        w_state_next = S_ISSUE;
                    end else begin
                        w_x_next = '0;
                        if (!w_last_y) begin
                            w_y_next     = r_y + c_yw'(1);
                            w_state_next = S_ISSUE;
                        end else begin
                            w_y_next     = '0;
                            w_state_next = continuous ? S_ISSUE : S_IDLE;
                        end
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Keep the coordinate issued in the ISSUE cycle visible until the next issue
    always_ff @(posedge clk or posedge r_rst_sync) begin
        if (r_rst_sync) begin
            r_screen_x <= '0;
            r_screen_y <= '0;
        end else if (r_state == S_ISSUE) begin
            r_screen_x <= w_coord_x;
            r_screen_y <= w_coord_y;
        end
    end

    // Capture the core result together with its frame and line markers
    always_ff @(posedge clk or posedge r_rst_sync) begin
        if (r_rst_sync) begin
            r_tdata <= '0;
            r_tuser <= 1'b0;
            r_tlast <= 1'b0;
        end else if (w_capture) begin
            r_tdata <= bus.shade_in;
            r_tuser <= (r_x == '0) && (r_y == '0);
            r_tlast <= w_last_x;
        end
    end

    // End-of-frame pulse and sticky protocol error flag. A result arriving
    // outside WAIT has no pixel to belong to, so it is dropped and flagged.
    always_ff @(posedge clk or posedge r_rst_sync) begin
        if (r_rst_sync) begin
            r_frame_done   <= 1'b0;
            r_spurious_err <= 1'b0;
        end else begin
            r_frame_done   <= w_frame_end;
            r_spurious_err <= r_spurious_err | (bus.shade_valid && (r_state != S_WAIT));
        end
    end

    assign bus.coord_valid   = (r_state == S_ISSUE);
    assign bus.screen_x      = (r_state == S_ISSUE) ? w_coord_x : r_screen_x;
    assign bus.screen_y      = (r_state == S_ISSUE) ? w_coord_y : r_screen_y;
    assign bus.m_axis_tvalid = (r_state == S_OUT);
    assign bus.m_axis_tdata  = r_tdata;
    assign bus.m_axis_tuser  = r_tuser;
    assign bus.m_axis_tlast  = r_tlast;
    assign busy              = (r_state != S_IDLE) || r_frame_done;
    assign frame_done        = r_frame_done;
    assign spurious_err      = r_spurious_err;

endmodule
`default_nettype wire

// File: tb/tb_raymarch_pixel_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_raymarch_pixel_sequencer
//  Description : Self-checking bench for raymarch_pixel_sequencer. A 4x2
//                instance runs against a pixel-index reference model with a
//                randomised core and sink. A 1x1 instance is driven by hand.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_raymarch_pixel_sequencer;

    localparam int W    = 4;
    localparam int H    = 2;
    localparam int FRAC = 21;
    localparam int CW   = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Main instance
    logic start = 1'b0;
    logic continuous = 1'b0;
    logic busy, frame_done, spurious_err;
    raymarch_pixel_sequencer_if #(.CW(CW)) bus_a ();
    raymarch_pixel_sequencer #(.WIDTH(W), .HEIGHT(H), .FRAC(FRAC), .CW(CW)) dut_a (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous), .bus(bus_a),
        .busy(busy), .frame_done(frame_done), .spurious_err(spurious_err)
    );

    // Single-pixel instance
    logic start_b = 1'b0;
    logic continuous_b = 1'b0;
    logic busy_b, frame_done_b, spurious_b;
    raymarch_pixel_sequencer_if #(.CW(CW)) bus_b ();
    raymarch_pixel_sequencer #(.WIDTH(1), .HEIGHT(1), .FRAC(FRAC), .CW(CW)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .continuous(continuous_b), .bus(bus_b),
        .busy(busy_b), .frame_done(frame_done_b), .spurious_err(spurious_b)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Stimulus controls (written by the stimulus process only)
    bit quiet       = 1'b1;
    bit rand_lat    = 1'b0;
    bit rand_ready  = 1'b0;
    bit rand_data   = 1'b0;
    int shade_base  = 0;
    int inj_idle_req = 0;
    int inj_out_req  = 0;

    // Core and sink model driving the main instance
    int core_cnt      = 0;
    int shade_ctr     = 0;
    int inj_idle_done = 0;
    int inj_out_done  = 0;

    // Core result arrives a fixed or random number of cycles after each request
    initial begin : drv
        bus_a.shade_valid   = 1'b0;
        bus_a.shade_in      = '0;
        bus_a.m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus_a.shade_valid   = 1'b0;
            bus_a.m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rst || quiet) begin
                core_cnt = 0;
            end else begin
                if (core_cnt > 0) begin
                    core_cnt--;
                    if (core_cnt == 0) begin
                        shade_ctr++;
                        bus_a.shade_valid = 1'b1;
                        bus_a.shade_in    = rand_data ? 24'($urandom) : 24'(shade_ctr - shade_base);
                    end
                end
                if (bus_a.coord_valid) core_cnt = rand_lat ? int'($urandom_range(1, 4)) : 3;
                if (inj_idle_req != inj_idle_done && !busy) begin
                    inj_idle_done     = inj_idle_req;
                    bus_a.shade_valid = 1'b1;
                    bus_a.shade_in    = 24'hBADBAD;
                end
                if (inj_out_req != inj_out_done && bus_a.m_axis_tvalid) begin
                    inj_out_done        = inj_out_req;
                    bus_a.m_axis_tready = 1'b0;
                    bus_a.shade_valid   = 1'b1;
                    bus_a.shade_in      = 24'hBADBAD;
                end
            end
        end
    end

    // Reference model: scan position as a linear pixel index, plus event flags
    bit          m_issue, m_wait, m_beat, m_done, m_active, m_spur;
    int          m_x, m_y;
    logic [23:0] m_bdata;
    bit          m_buser, m_blast;
    logic [31:0] m_sx, m_sy;
    int          n_coord = 0;
    int          n_done  = 0;
    logic [23:0] hs_data[$];
    bit          hs_user[$];
    bit          hs_last[$];

    // Compare every cycle against the model, then advance the model
    always @(negedge clk) begin : cmp
        bit act0;
        bit n_issue;
        bit n_fd;
        int idx;
        if (rst || quiet) begin
            m_issue = 0; m_wait = 0; m_beat = 0; m_done = 0; m_active = 0; m_spur = 0;
            m_x = 0; m_y = 0; m_sx = '0; m_sy = '0;
        end else begin
            if (m_issue) begin
                m_sx = 32'(m_x) << FRAC;
                m_sy = 32'(m_y) << FRAC;
            end
            chk("coord_valid", bus_a.coord_valid, m_issue);
            chk("screen_x", bus_a.screen_x, m_sx);
            chk("screen_y", bus_a.screen_y, m_sy);
            chk("tvalid", bus_a.m_axis_tvalid, m_beat);
            if (m_beat) begin
                chk("tdata", bus_a.m_axis_tdata, m_bdata);
                chk("tuser", bus_a.m_axis_tuser, m_buser);
                chk("tlast", bus_a.m_axis_tlast, m_blast);
            end
            chk("frame_done", frame_done, m_done);
            chk("busy", busy, m_active || m_done);
            chk("spurious_err", spurious_err, m_spur);
            if (bus_a.coord_valid) n_coord++;
            if (frame_done) n_done++;

            act0    = m_active;
            n_issue = 0;
            n_fd    = 0;
            if (bus_a.shade_valid && !m_wait) m_spur = 1;
            if (m_wait) begin
                if (bus_a.shade_valid) begin
                    m_wait  = 0;
                    m_beat  = 1;
                    m_bdata = bus_a.shade_in;
                    m_buser = (m_x == 0) && (m_y == 0);
                    m_blast = (m_x == W - 1);
                end
            end else if (m_beat) begin
                if (bus_a.m_axis_tready) begin
                    hs_data.push_back(bus_a.m_axis_tdata);
                    hs_user.push_back(bus_a.m_axis_tuser);
                    hs_last.push_back(bus_a.m_axis_tlast);
                    m_beat = 0;
                    idx = m_y * W + m_x + 1;
                    if (idx == W * H) begin
                        m_x = 0; m_y = 0; n_fd = 1;
                        if (continuous) n_issue = 1;
                        else m_active = 0;
                    end else begin
                        m_x = idx % W; m_y = idx / W; n_issue = 1;
                    end
                end
            end else if (m_issue) begin
                m_wait = 1;
            end
            if (!act0 && !m_done && start) begin
                m_active = 1; m_x = 0; m_y = 0; n_issue = 1;
            end
            m_issue = n_issue;
            m_done  = n_fd;
        end
    end

    task automatic wait_done(input string nm);
        int k;
        k = 0;
        cyc(1);
        while (!frame_done && k < 3000) begin
            cyc(1);
            k++;
        end
        chk(nm, frame_done, 1'b1);
    endtask

    task automatic chk_frame(input string nm, input int b, input int nbeats,
                             input logic [15:0] user_pat, input logic [15:0] last_pat);
        logic [15:0] pu;
        logic [15:0] pl;
        pu = '0;
        pl = '0;
        chk({nm, "_beats"}, hs_data.size() - b, nbeats);
        for (int i = 0; i < nbeats; i++) begin
            if (b + i < hs_data.size()) begin
                pu[i] = hs_user[b + i];
                pl[i] = hs_last[b + i];
            end
        end
        chk({nm, "_tuser_pattern"}, pu, user_pat);
        chk({nm, "_tlast_pattern"}, pl, last_pat);
    endtask

    initial begin : stim
        int bc;
        int bb;
        int bd;
        int found;
        int extra;
        bus_b.shade_valid   = 1'b0;
        bus_b.shade_in      = '0;
        bus_b.m_axis_tready = 1'b1;

        // Reset values
        cyc(3);
        chk("rst_ctrl", {bus_a.coord_valid, bus_a.m_axis_tvalid, bus_a.m_axis_tuser,
                         bus_a.m_axis_tlast, busy, frame_done, spurious_err}, 0);
        chk("rst_screen_x", bus_a.screen_x, 0);
        chk("rst_tdata", bus_a.m_axis_tdata, 0);
        rst = 1'b0;
        cyc(4);
        quiet = 1'b0;
        cyc(2);

        // Frame with fixed latency, always-ready sink, counting shades
        bc = n_coord; bb = hs_data.size(); bd = n_done;
        shade_base = shade_ctr;
        start = 1'b1; cyc(1); start = 1'b0;
        wait_done("t1_frame_done");
        chk("t1_busy_in_done_cycle", busy, 1);
        cyc(1);
        chk("t1_busy_low_after", busy, 0);
        chk("t1_screen_x_hold", bus_a.screen_x, 32'h0060_0000);
        chk("t1_screen_y_hold", bus_a.screen_y, 32'h0020_0000);
        cyc(2);
        chk("t1_coord_pulses", n_coord - bc, 8);
        chk("t1_done_count", n_done - bd, 1);
        chk_frame("t1", bb, 8, 16'h0001, 16'h0088);
        for (int i = 0; i < 8; i++)
            if (bb + i < hs_data.size()) chk("t1_data", hs_data[bb + i], i + 1);

        // Back-pressured sink
        bb = hs_data.size();
        shade_base = shade_ctr;
        rand_ready = 1'b1;
        start = 1'b1; cyc(1); start = 1'b0;
        wait_done("t2_frame_done");
        cyc(2);
        rand_ready = 1'b0;
        chk_frame("t2", bb, 8, 16'h0001, 16'h0088);
        for (int i = 0; i < 8; i++)
            if (bb + i < hs_data.size()) chk("t2_data", hs_data[bb + i], i + 1);

        // Stray results in IDLE and during OUT
        inj_idle_req++;
        cyc(3);
        chk("t4_spur_idle", spurious_err, 1);
        bb = hs_data.size();
        rand_lat = 1'b1; rand_data = 1'b1; rand_ready = 1'b1;
        inj_out_req++;
        start = 1'b1; cyc(1); start = 1'b0;
        wait_done("t4_frame_done");
        cyc(2);
        rand_data = 1'b0; rand_ready = 1'b0;
        chk("t4_spur_sticky", spurious_err, 1);
        chk("t4_inject_used", inj_out_done, inj_out_req);
        chk_frame("t4", bb, 8, 16'h0001, 16'h0088);

        // Two back-to-back frames
        bb = hs_data.size(); bc = n_coord; bd = n_done;
        shade_base = shade_ctr;
        continuous = 1'b1;
        start = 1'b1; cyc(1); start = 1'b0;
        wait_done("t3_first_done");
        continuous = 1'b0;
        chk("t3_restart_issue", bus_a.coord_valid, 1);
        chk("t3_restart_x", bus_a.screen_x, 0);
        wait_done("t3_second_done");
        cyc(2);
        chk("t3_coord_pulses", n_coord - bc, 16);
        chk("t3_done_count", n_done - bd, 2);
        chk_frame("t3", bb, 16, 16'h0101, 16'h8888);

        // Reset while waiting on pixel (2,1)
        rand_lat = 1'b0;
        start = 1'b1; cyc(1); start = 1'b0;
        found = 0;
        for (int k = 0; k < 300 && found == 0; k++) begin
            cyc(1);
            if (bus_a.coord_valid && bus_a.screen_x == 32'h0040_0000 && bus_a.screen_y == 32'h0020_0000)
                found = 1;
        end
        chk("t5_reach_pixel_2_1", found, 1);
        cyc(1);
        #1;
        quiet = 1'b1;
        rst   = 1'b1;
        #1;
        chk("t5_async_ctrl", {bus_a.coord_valid, bus_a.m_axis_tvalid, bus_a.m_axis_tuser,
                              bus_a.m_axis_tlast, busy, frame_done, spurious_err}, 0);
        chk("t5_async_screen_x", bus_a.screen_x, 0);
        chk("t5_async_screen_y", bus_a.screen_y, 0);
        chk("t5_async_tdata", bus_a.m_axis_tdata, 0);
        cyc(3);
        rst = 1'b0;
        cyc(4);
        quiet = 1'b0;
        cyc(1);
        inj_idle_req++;
        cyc(3);
        chk("t5_late_shade_spur", spurious_err, 1);
        bb = hs_data.size();
        shade_base = shade_ctr;
        start = 1'b1; cyc(1); start = 1'b0;
        chk("t5_first_issue_x", bus_a.screen_x, 0);
        chk("t5_first_issue_y", bus_a.screen_y, 0);
        wait_done("t5_frame_done");
        cyc(2);
        chk_frame("t5", bb, 8, 16'h0001, 16'h0088);

        // Single-pixel frame, with start pulses while busy
        start_b = 1'b1; cyc(1); start_b = 1'b0;
        chk("t6_issue", bus_b.coord_valid, 1);
        chk("t6_screen_x", bus_b.screen_x, 0);
        cyc(1);
        chk("t6_busy_wait", busy_b, 1);
        start_b = 1'b1;
        bus_b.shade_valid = 1'b1;
        bus_b.shade_in    = 24'h123456;
        cyc(1);
        bus_b.shade_valid = 1'b0;
        chk("t6_tvalid", bus_b.m_axis_tvalid, 1);
        chk("t6_tdata", bus_b.m_axis_tdata, 32'h0012_3456);
        chk("t6_tuser", bus_b.m_axis_tuser, 1);
        chk("t6_tlast", bus_b.m_axis_tlast, 1);
        cyc(1);
        start_b = 1'b0;
        chk("t6_frame_done", frame_done_b, 1);
        chk("t6_tvalid_cleared", bus_b.m_axis_tvalid, 0);
        cyc(1);
        chk("t6_busy_low", busy_b, 0);
        extra = 0;
        repeat (6) begin
            cyc(1);
            if (bus_b.coord_valid || busy_b) extra++;
        end
        chk("t6_no_extra_frame", extra, 0);
        chk("t6_no_spur", spurious_b, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: run did not complete, %0d/%0d so far", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
